// File: rtl/sample_printer_pkg.sv
// Shared states, ASCII constants and width helper for the sample printer.
// Imported by hex_ascii_encoder and sample_hex_printer.
package sample_printer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHAN,
    S_COLON,
    S_HEX,
    S_SEP,
    S_CR,
    S_LF
  } state_t;

  localparam logic [7:0] CH_COLON   = 8'h3A;
  localparam logic [7:0] CH_SPACE   = 8'h20;
  localparam logic [7:0] CH_CR      = 8'h0D;
  localparam logic [7:0] CH_LF      = 8'h0A;
  localparam logic [7:0] CH_ZERO    = 8'h30;
  localparam logic [7:0] CH_A       = 8'h41;
  localparam logic [7:0] CMD_PAUSE  = 8'h70;
  localparam logic [7:0] CMD_RESUME = 8'h72;

  function automatic int hex_digits(input int w);
    return (w + 3) / 4;
  endfunction

endpackage

// File: rtl/hex_ascii_encoder.sv
// Combinational nibble to uppercase ASCII hex character.
// Ports: nibble_i (4-bit value), ascii_o (8-bit '0'-'9' / 'A'-'F').
module hex_ascii_encoder
  import sample_printer_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [7:0] ascii_o
);

  always_comb begin
    if (nibble_i < 4'd10) begin
      ascii_o = CH_ZERO + {4'h0, nibble_i};
    end else begin
      ascii_o = CH_A + {4'h0, nibble_i} - 8'd10;
    end
  end

endmodule

// File: rtl/sample_hex_printer.sv
// Streams each captured multi-channel sample as one ASCII hex line to a UART.
// Ports: clk/rst, sample_data/new_sample in, tx_data/new_tx_data/tx_busy to
// the transmitter, rx_data/new_rx_data pause commands, busy/overrun status.
module sample_hex_printer
  import sample_printer_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int SAMPLE_W = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH*SAMPLE_W-1:0] sample_data,
  input  logic                       new_sample,
  output logic [7:0]                 tx_data,
  output logic                       new_tx_data,
  input  logic                       tx_busy,
  input  logic [7:0]                 rx_data,
  input  logic                       new_rx_data,
  output logic                       busy,
  output logic                       overrun
);

  localparam int HEX_DIGITS = hex_digits(SAMPLE_W);
  localparam int HW = HEX_DIGITS * 4;
  localparam int PW = NUM_CH * HW;
  localparam int IW = $clog2(PW);
  localparam int DW = NUM_CH * SAMPLE_W;

  state_t          state_q, state_d;
  logic [3:0]      ch_q, ch_d;
  logic [3:0]      dig_q, dig_d;
  logic [DW-1:0]   frame_q, frame_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            new_tx_data_q, new_tx_data_d;
  logic            busy_q, busy_d;
  logic            overrun_q, overrun_d;
  logic            paused_q, paused_d;

  logic [PW-1:0]   padded;
  logic [IW-1:0]   nib_base;
  logic [3:0]      nibble;
  logic [7:0]      hex_char;
  logic            hold;
  logic            can_emit;
  logic            emit;
  logic [7:0]      emit_byte;
  logic            pause_cmd;
  logic            resume_cmd;
  logic            paused_eff;

  // Each channel zero-extended to a whole number of nibbles.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_pad
    assign padded[c*HW +: SAMPLE_W] = frame_q[c*SAMPLE_W +: SAMPLE_W];
    if (HW > SAMPLE_W) begin : g_ext
      assign padded[c*HW+SAMPLE_W +: HW-SAMPLE_W] = '0;
    end
  end

  assign nib_base = IW'(int'(ch_q) * HW + (HEX_DIGITS - 1 - int'(dig_q)) * 4);
  assign nibble   = padded[nib_base +: 4];

  hex_ascii_encoder u_enc (
    .nibble_i (nibble),
    .ascii_o  (hex_char)
  );

  // The registered strobe doubles as the post-emission hold flag; it
  // covers the cycle before the transmitter can raise tx_busy.
  assign hold     = new_tx_data_q;
  assign can_emit = !tx_busy && !hold;

  assign pause_cmd  = new_rx_data && (rx_data == CMD_PAUSE);
  assign resume_cmd = new_rx_data && (rx_data == CMD_RESUME);
  // A pause arriving with a sample already blocks that sample.
  assign paused_eff = paused_q || pause_cmd;

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    dig_d     = dig_q;
    frame_d   = frame_q;
    emit      = 1'b0;
    emit_byte = 8'h00;
    unique case (state_q)
      S_IDLE: begin
        if (new_sample && !busy_q && !paused_eff) begin
          frame_d = sample_data;
          ch_d    = '0;
          dig_d   = '0;
          // First label goes out straight from capture to meet latency.
          if (!tx_busy) begin
            emit      = 1'b1;
            emit_byte = CH_ZERO;
            state_d   = S_COLON;
          end else begin
            state_d = S_CHAN;
          end
        end
      end
      S_CHAN: begin
        if (can_emit) begin
          emit      = 1'b1;
          emit_byte = CH_ZERO + {4'h0, ch_q};
          state_d   = S_COLON;
        end
      end
      S_COLON: begin
        if (can_emit) begin
          emit      = 1'b1;
          emit_byte = CH_COLON;
          state_d   = S_HEX;
        end
      end
      S_HEX: begin
        if (can_emit) begin
          emit      = 1'b1;
          emit_byte = hex_char;
          if (dig_q == 4'(HEX_DIGITS - 1)) begin
            dig_d   = '0;
            state_d = (ch_q == 4'(NUM_CH - 1)) ? S_CR : S_SEP;
          end else begin
            dig_d = dig_q + 4'd1;
          end
        end
      end
      S_SEP: begin
        if (can_emit) begin
          emit      = 1'b1;
          emit_byte = CH_SPACE;
          ch_d      = ch_q + 4'd1;
          state_d   = S_CHAN;
        end
      end
      S_CR: begin
        if (can_emit) begin
          emit      = 1'b1;
          emit_byte = CH_CR;
          state_d   = S_LF;
        end
      end
      S_LF: begin
        if (can_emit) begin
          emit      = 1'b1;
          emit_byte = CH_LF;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // busy stays up through the cycle the LF strobe is visible.
  assign busy_d        = (state_d != S_IDLE) || emit;
  assign new_tx_data_d = emit;
  assign tx_data_d     = emit ? emit_byte : tx_data_q;
  assign overrun_d     = new_sample && busy_q && !paused_eff;
  assign paused_d      = pause_cmd ? 1'b1 : (resume_cmd ? 1'b0 : paused_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      ch_q          <= '0;
      dig_q         <= '0;
      frame_q       <= '0;
      tx_data_q     <= 8'h00;
      new_tx_data_q <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
      paused_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      ch_q          <= ch_d;
      dig_q         <= dig_d;
      frame_q       <= frame_d;
      tx_data_q     <= tx_data_d;
      new_tx_data_q <= new_tx_data_d;
      busy_q        <= busy_d;
      overrun_q     <= overrun_d;
      paused_q      <= paused_d;
    end
  end

  assign tx_data     = tx_data_q;
  assign new_tx_data = new_tx_data_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_sample_hex_printer.sv
// Directed bench for sample_hex_printer: default build plus two
// single-channel width variants.
module tb_sample_hex_printer;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [23:0] sd_a;
  logic        ns_a;
  logic [7:0]  txd_a;
  logic        ntx_a;
  logic        txb_a;
  logic [7:0]  rxd;
  logic        nrx;
  logic        busy_a;
  logic        ov_a;

  logic [9:0]  sd_b;
  logic        ns_b;
  logic [7:0]  txd_b;
  logic        ntx_b;
  logic        busy_b;
  logic        ov_b;

  logic [15:0] sd_c;
  logic        ns_c;
  logic [7:0]  txd_c;
  logic        ntx_c;
  logic        busy_c;
  logic        ov_c;

  sample_hex_printer #(.NUM_CH(2), .SAMPLE_W(12)) u_a (
    .clk(clk), .rst(rst), .sample_data(sd_a), .new_sample(ns_a),
    .tx_data(txd_a), .new_tx_data(ntx_a), .tx_busy(txb_a),
    .rx_data(rxd), .new_rx_data(nrx), .busy(busy_a), .overrun(ov_a)
  );

  sample_hex_printer #(.NUM_CH(1), .SAMPLE_W(10)) u_b (
    .clk(clk), .rst(rst), .sample_data(sd_b), .new_sample(ns_b),
    .tx_data(txd_b), .new_tx_data(ntx_b), .tx_busy(1'b0),
    .rx_data(8'h00), .new_rx_data(1'b0), .busy(busy_b), .overrun(ov_b)
  );

  sample_hex_printer #(.NUM_CH(1), .SAMPLE_W(16)) u_c (
    .clk(clk), .rst(rst), .sample_data(sd_c), .new_sample(ns_c),
    .tx_data(txd_c), .new_tx_data(ntx_c), .tx_busy(1'b0),
    .rx_data(8'h00), .new_rx_data(1'b0), .busy(busy_c), .overrun(ov_c)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: busy for busy_len cycles after each strobe.
  int busy_len = 0;
  int busy_cnt = 0;
  always @(posedge clk) begin
    if (ntx_a && busy_len > 0) busy_cnt <= busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign txb_a = (busy_cnt != 0);

  logic [7:0] qa[$];
  int         qc[$];
  logic [7:0] qb[$];
  logic [7:0] qcc[$];
  int         consec;
  int         strobe_busy;
  int         ov_n;
  int         ov_cyc;
  int         last_busy;
  bit         prev_ntx;

  always @(negedge clk) begin
    if (ntx_a) begin
      if (prev_ntx) consec++;
      if (txb_a) strobe_busy++;
      qa.push_back(txd_a);
      qc.push_back(cyc);
    end
    prev_ntx = ntx_a;
    if (busy_a) last_busy = cyc;
    if (ov_a) begin
      ov_n++;
      ov_cyc = cyc;
    end
    if (ntx_b) qb.push_back(txd_b);
    if (ntx_c) qcc.push_back(txd_c);
  end

  int n_cmp = 0;
  int n_err = 0;

  function automatic bq_t mk_frame(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    q.push_back(8'h0D);
    q.push_back(8'h0A);
    return q;
  endfunction

  task automatic clear_mon();
    qa.delete();
    qc.delete();
    qb.delete();
    qcc.delete();
    consec = 0;
    strobe_busy = 0;
    ov_n = 0;
    ov_cyc = -1;
  endtask

  task automatic drive_sample(input logic [23:0] v, output int k);
    @(posedge clk);
    #1;
    sd_a = v;
    ns_a = 1'b1;
    k = cyc;
    @(posedge clk);
    #1;
    ns_a = 1'b0;
  endtask

  task automatic pulse_at(input int target, input logic [23:0] v);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
    sd_a = v;
    ns_a = 1'b1;
    @(posedge clk);
    #1;
    ns_a = 1'b0;
  endtask

  task automatic rx_at(input int target, input logic [7:0] b);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
    rxd = b;
    nrx = 1'b1;
    @(posedge clk);
    #1;
    nrx = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, output bit to);
    to = 1'b1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (!busy_a && qa.size() > 0 && qa[qa.size()-1] == 8'h0A) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_cmp++;
    if (txd_a !== 8'h00) begin
      n_err++;
      $display("FAIL reset_tx_data: got %h want 00", txd_a);
    end
    n_cmp++;
    if (ntx_a !== 1'b0) begin
      n_err++;
      $display("FAIL reset_new_tx_data: got %b want 0", ntx_a);
    end
    n_cmp++;
    if (busy_a !== 1'b0) begin
      n_err++;
      $display("FAIL reset_busy: got %b want 0", busy_a);
    end
    n_cmp++;
    if (ov_a !== 1'b0) begin
      n_err++;
      $display("FAIL reset_overrun: got %b want 0", ov_a);
    end
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int k;
    bit to;
    bq_t exp;
    logic [7:0] got;
    clear_mon();
    busy_len = 0;
    drive_sample(24'h123ABC, k);
    wait_idle(100, to);
    exp = mk_frame("0:ABC 1:123");
    n_cmp++;
    if (to) begin
      n_err++;
      $display("FAIL basic_timeout: got busy/no LF want frame end");
    end
    n_cmp++;
    if (qa.size() != exp.size()) begin
      n_err++;
      $display("FAIL basic_len: got %0d want %0d", qa.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < qa.size()) ? qa[i] : 8'hxx;
      n_cmp++;
      if (got !== exp[i]) begin
        n_err++;
        $display("FAIL basic_byte%0d: got %h want %h", i, got, exp[i]);
      end
    end
    if (qa.size() == exp.size()) begin
      n_cmp++;
      if (qc[0] != k + 1) begin
        n_err++;
        $display("FAIL basic_latency: got %0d want %0d", qc[0], k + 1);
      end
      for (int i = 1; i < qc.size(); i++) begin
        n_cmp++;
        if (qc[i] - qc[i-1] != 2) begin
          n_err++;
          $display("FAIL basic_gap%0d: got %0d want 2", i, qc[i] - qc[i-1]);
        end
      end
      n_cmp++;
      if (last_busy != qc[12]) begin
        n_err++;
        $display("FAIL basic_busy_fall: got last busy %0d want %0d",
                 last_busy, qc[12]);
      end
    end
    n_cmp++;
    if (consec != 0) begin
      n_err++;
      $display("FAIL basic_consec: got %0d want 0", consec);
    end
  endtask

  task automatic test_busy_handshake();
    int k;
    bit to;
    bq_t exp;
    logic [7:0] got;
    clear_mon();
    busy_len = 5;
    drive_sample(24'h123ABC, k);
    wait_idle(300, to);
    exp = mk_frame("0:ABC 1:123");
    n_cmp++;
    if (qa.size() != exp.size() || to) begin
      n_err++;
      $display("FAIL hs_len: got %0d want %0d", qa.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < qa.size()) ? qa[i] : 8'hxx;
      n_cmp++;
      if (got !== exp[i]) begin
        n_err++;
        $display("FAIL hs_byte%0d: got %h want %h", i, got, exp[i]);
      end
    end
    for (int i = 1; i < qc.size(); i++) begin
      n_cmp++;
      if (qc[i] - qc[i-1] != 7) begin
        n_err++;
        $display("FAIL hs_gap%0d: got %0d want 7", i, qc[i] - qc[i-1]);
      end
    end
    n_cmp++;
    if (strobe_busy != 0) begin
      n_err++;
      $display("FAIL hs_strobe_busy: got %0d want 0", strobe_busy);
    end
    busy_len = 0;
    repeat (8) @(posedge clk);
  endtask

  task automatic test_overrun();
    int k;
    bit to;
    bq_t exp;
    logic [7:0] got;
    clear_mon();
    drive_sample(24'h123ABC, k);
    pulse_at(k + 6, 24'hFFFFFF);
    wait_idle(100, to);
    repeat (40) @(negedge clk);
    exp = mk_frame("0:ABC 1:123");
    n_cmp++;
    if (ov_n != 1) begin
      n_err++;
      $display("FAIL ovr_count: got %0d want 1", ov_n);
    end
    n_cmp++;
    if (ov_cyc != k + 7) begin
      n_err++;
      $display("FAIL ovr_cycle: got %0d want %0d", ov_cyc, k + 7);
    end
    n_cmp++;
    if (qa.size() != exp.size() || to) begin
      n_err++;
      $display("FAIL ovr_len: got %0d want %0d", qa.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < qa.size()) ? qa[i] : 8'hxx;
      n_cmp++;
      if (got !== exp[i]) begin
        n_err++;
        $display("FAIL ovr_byte%0d: got %h want %h", i, got, exp[i]);
      end
    end
  endtask

  task automatic test_lf_overrun();
    int k;
    clear_mon();
    drive_sample(24'h123ABC, k);
    pulse_at(k + 25, 24'h000000);
    repeat (40) @(negedge clk);
    n_cmp++;
    if (qc.size() != 13 || qc[qc.size()-1] != k + 25) begin
      n_err++;
      $display("FAIL lf_timing: got %0d strobes want 13 ending at %0d",
               qc.size(), k + 25);
    end
    n_cmp++;
    if (ov_n != 1 || ov_cyc != k + 26) begin
      n_err++;
      $display("FAIL lf_overrun: got %0d at %0d want 1 at %0d",
               ov_n, ov_cyc, k + 26);
    end
  endtask

  task automatic test_back_to_back();
    int k;
    bit to;
    bq_t exp;
    logic [7:0] got;
    clear_mon();
    drive_sample(24'h123ABC, k);
    pulse_at(k + 26, 24'h00F7E1);
    repeat (2) @(negedge clk);
    wait_idle(100, to);
    exp = {mk_frame("0:ABC 1:123"), mk_frame("0:7E1 1:00F")};
    n_cmp++;
    if (qa.size() != exp.size() || to) begin
      n_err++;
      $display("FAIL b2b_len: got %0d want %0d", qa.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < qa.size()) ? qa[i] : 8'hxx;
      n_cmp++;
      if (got !== exp[i]) begin
        n_err++;
        $display("FAIL b2b_byte%0d: got %h want %h", i, got, exp[i]);
      end
    end
    n_cmp++;
    if (qc.size() < 14 || qc[13] != k + 27) begin
      n_err++;
      $display("FAIL b2b_restart: got %0d want %0d",
               (qc.size() > 13) ? qc[13] : -1, k + 27);
    end
    n_cmp++;
    if (ov_n != 0) begin
      n_err++;
      $display("FAIL b2b_overrun: got %0d want 0", ov_n);
    end
  endtask

  task automatic test_pause();
    int k;
    bit to;
    bq_t exp;
    logic [7:0] got;
    clear_mon();
    drive_sample(24'h123ABC, k);
    rx_at(k + 4, "p");
    wait_idle(100, to);
    exp = mk_frame("0:ABC 1:123");
    n_cmp++;
    if (qa.size() != exp.size() || to) begin
      n_err++;
      $display("FAIL pause_len: got %0d want %0d", qa.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < qa.size()) ? qa[i] : 8'hxx;
      n_cmp++;
      if (got !== exp[i]) begin
        n_err++;
        $display("FAIL pause_byte%0d: got %h want %h", i, got, exp[i]);
      end
    end
    clear_mon();
    drive_sample(24'h111111, k);
    repeat (40) @(negedge clk);
    n_cmp++;
    if (qa.size() != 0 || ov_n != 0 || busy_a !== 1'b0) begin
      n_err++;
      $display("FAIL paused_quiet: got %0d bytes %0d overruns busy %b want 0 0 0",
               qa.size(), ov_n, busy_a);
    end
    rx_at(cyc + 1, "r");
    clear_mon();
    drive_sample(24'h00F7E1, k);
    wait_idle(100, to);
    exp = mk_frame("0:7E1 1:00F");
    n_cmp++;
    if (qa.size() != exp.size() || to) begin
      n_err++;
      $display("FAIL resume_len: got %0d want %0d", qa.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < qa.size()) ? qa[i] : 8'hxx;
      n_cmp++;
      if (got !== exp[i]) begin
        n_err++;
        $display("FAIL resume_byte%0d: got %h want %h", i, got, exp[i]);
      end
    end
    clear_mon();
    @(posedge clk);
    #1;
    sd_a = 24'h222222;
    ns_a = 1'b1;
    rxd  = "p";
    nrx  = 1'b1;
    @(posedge clk);
    #1;
    ns_a = 1'b0;
    nrx  = 1'b0;
    repeat (40) @(negedge clk);
    n_cmp++;
    if (qa.size() != 0 || ov_n != 0) begin
      n_err++;
      $display("FAIL pause_same_cycle: got %0d bytes %0d overruns want 0 0",
               qa.size(), ov_n);
    end
    rx_at(cyc + 1, "r");
  endtask

  task automatic test_reset_mid();
    int k;
    bit to;
    bq_t exp;
    logic [7:0] got;
    clear_mon();
    drive_sample(24'h123ABC, k);
    while (cyc < k + 7) begin
      @(posedge clk);
      #1;
    end
    #2;
    n_cmp++;
    if (ntx_a !== 1'b1 || txd_a !== 8'h42) begin
      n_err++;
      $display("FAIL rstmid_4th: got %b/%h want 1/42", ntx_a, txd_a);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (ntx_a !== 1'b0 || txd_a !== 8'h00 || busy_a !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_async: got %b/%h/%b want 0/00/0",
               ntx_a, txd_a, busy_a);
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    clear_mon();
    repeat (10) @(negedge clk);
    n_cmp++;
    if (qa.size() != 0) begin
      n_err++;
      $display("FAIL rstmid_trailing: got %0d want 0", qa.size());
    end
    drive_sample(24'h123ABC, k);
    wait_idle(100, to);
    exp = mk_frame("0:ABC 1:123");
    n_cmp++;
    if (qa.size() != exp.size() || to) begin
      n_err++;
      $display("FAIL rstmid_len: got %0d want %0d", qa.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < qa.size()) ? qa[i] : 8'hxx;
      n_cmp++;
      if (got !== exp[i]) begin
        n_err++;
        $display("FAIL rstmid_byte%0d: got %h want %h", i, got, exp[i]);
      end
    end
  endtask

  task automatic test_widths();
    bq_t exp;
    logic [7:0] got;
    clear_mon();
    @(posedge clk);
    #1;
    sd_b = 10'h3FF;
    sd_c = 16'h00A5;
    ns_b = 1'b1;
    ns_c = 1'b1;
    @(posedge clk);
    #1;
    ns_b = 1'b0;
    ns_c = 1'b0;
    repeat (30) @(negedge clk);
    exp = mk_frame("0:3FF");
    n_cmp++;
    if (qb.size() != exp.size()) begin
      n_err++;
      $display("FAIL w10_len: got %0d want %0d", qb.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < qb.size()) ? qb[i] : 8'hxx;
      n_cmp++;
      if (got !== exp[i]) begin
        n_err++;
        $display("FAIL w10_byte%0d: got %h want %h", i, got, exp[i]);
      end
    end
    exp = mk_frame("0:00A5");
    n_cmp++;
    if (qcc.size() != exp.size()) begin
      n_err++;
      $display("FAIL w16_len: got %0d want %0d", qcc.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < qcc.size()) ? qcc[i] : 8'hxx;
      n_cmp++;
      if (got !== exp[i]) begin
        n_err++;
        $display("FAIL w16_byte%0d: got %h want %h", i, got, exp[i]);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst  = 1'b1;
    sd_a = '0;
    ns_a = 1'b0;
    rxd  = 8'h00;
    nrx  = 1'b0;
    sd_b = '0;
    ns_b = 1'b0;
    sd_c = '0;
    ns_c = 1'b0;
    test_reset();
    test_basic();
    test_busy_handshake();
    test_overrun();
    test_lf_overrun();
    test_back_to_back();
    test_pause();
    test_reset_mid();
    test_widths();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
